// File: rtl/niosii_processor_key_in.sv
// niosii_processor_key_in: Avalon-MM push-button input port with debounce,
// per-bit edge capture (write-1-to-clear) and a masked level interrupt.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   address[1:0]            word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//   chipselect, write_n     write strobe is chipselect & ~write_n
//   writedata[31:0]         write data (low WIDTH bits used)
//   in_port[WIDTH-1:0]      raw asynchronous button lines
//   readdata[31:0]          combinational read data, zero-extended
//   irq                     |(edgecapture & irqmask)
module niosii_processor_key_in #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};
    localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr;
    logic [CW-1:0]    cnt   [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             wr_en;
    logic             unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign unused_wd = ^writedata;

    // A bit is accepted only after sync2 has disagreed with deb for
    // DEBOUNCE_CYCLES consecutive cycles; agreeing at any point restarts.
    always_comb begin
        deb_d   = deb;
        edge_ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != deb[i]) begin
                if (cnt[i] == LAST) begin
                    deb_d[i]   = sync2[i];
                    edge_ev[i] = (deb[i] == IDLE_LEVEL);
                end else begin
                    cnt_d[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= IDLE;
            sync2       <= IDLE;
            deb         <= IDLE;
            irqmask     <= '0;
            edgecapture <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            deb   <= deb_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_d[i];
            end
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // Set has priority over clear so no edge is lost.
            edgecapture <= (edgecapture & ~clr) | edge_ev;
        end
    end

    assign irq = |(edgecapture & irqmask);

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata[WIDTH-1:0] = deb;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            2'd3:    readdata[WIDTH-1:0] = edgecapture;
            default: readdata = '0;
        endcase
    end

endmodule
